mdu_iterative: RTL and testbench

Iterative multiply/divide unit alongside the ALU in the single-cycle CPU datapath. It consumes the two register-file read operands (RS, RT) and produces a 64-bit HI/LO result for MULT/MULTU/DIV/DIVU. It uses a start/busy/done handshake, so the control path stalls the PC while the unit works. The unit computes one bit per cycle: radix-2 shift-add for multiply, restoring division for divide.

---
 rtl/mdu_iterative_if.sv | 14 +
 rtl/mdu_iterative.sv | 81 ++++++++
 tb/tb_mdu_iterative.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if: start/busy/done handshake and HI/LO result bus of the multiply/divide unit
interface mdu_iterative_if #(parameter int DATA_W = 32);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_zero;
    modport master (output start, op, src1, src2, input busy, done, hi, lo, div_zero);
    modport slave (input start, op, src1, src2, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: one-bit-per-cycle MULT/MULTU/DIV/DIVU unit (shift-add multiply, restoring divide)
module mdu_iterative (
    input  logic           clk_i,
    input  logic           rst_i,
    mdu_iterative_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        is_div, neg, rneg, dz, dz_q;
    logic [31:0] opnd, src1, hi_q, lo_q, m1, m2, quo, rem;
    logic [63:0] acc, prod;
    logic [32:0] sum, diff;
    logic        accept, sgn;

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign sgn    = !bus.op[0];
    assign m1     = (sgn && bus.src1[31]) ? -bus.src1 : bus.src1;
    assign m2     = (sgn && bus.src2[31]) ? -bus.src2 : bus.src2;
    // multiply keeps the 33-bit carry of the upper-half add; divide trial-subtracts from the shifted upper 33 bits
    assign sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign diff   = acc[63:31] - {1'b0, opnd};
    assign prod   = neg ? -acc : acc;
    assign quo    = neg ? -acc[31:0] : acc[31:0];
    assign rem    = rneg ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CALC : IDLE;
            CALC:    state_nx = (cnt == 5'd31) ? SIGN : CALC;
            SIGN:    state_nx = DONE;
            default: state_nx = accept ? CALC : IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg    <= 1'b0;
            rneg   <= 1'b0;
            dz     <= 1'b0;
            dz_q   <= 1'b0;
            opnd   <= '0;
            src1   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (accept) begin
            cnt    <= '0;
            is_div <= bus.op[1];
            neg    <= sgn && (bus.src1[31] ^ bus.src2[31]);
            rneg   <= sgn && bus.src1[31];
            dz     <= bus.op[1] && (bus.src2 == 32'd0);
            dz_q   <= 1'b0;
            opnd   <= bus.op[1] ? m2 : m1;
            src1   <= bus.src1;
            acc    <= {32'd0, bus.op[1] ? m1 : m2};
        end else if (state == CALC) begin
            cnt    <= cnt + 5'd1;
            acc    <= !is_div ? {sum, acc[31:1]} :
                      diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
        end else if (state == SIGN) begin
            hi_q   <= dz ? src1 : is_div ? rem : prod[63:32];
            lo_q   <= dz ? 32'hFFFF_FFFF : is_div ? quo : prod[31:0];
            dz_q   <= dz;
        end
    end

    assign bus.busy     = (state == CALC) || (state == SIGN);
    assign bus.done     = (state == DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: scoreboard bench; driver queues expected results, monitor checks each done pulse
module tb_mdu_iterative;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
        string       name;
    } exp_t;
    exp_t q[$];

    mdu_iterative_if bus ();
    mdu_iterative dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // reference: plain arithmetic on 64-bit integers, division truncates toward zero
    function automatic logic [64:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        case (op)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                p[31:0]  = 32'(sa / sb);
                p[63:32] = 32'(sa % sb);
            end
            default: begin
                p[31:0]  = a / b;
                p[63:32] = a % b;
            end
        endcase
        return {1'b0, p};
    endfunction

    // called #1 after a clock edge; start is sampled at the next edge
    task automatic issue_exp(string n, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                             logic [31:0] hi, logic [31:0] lo, logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        e.due = cyc + 34;
        e.name = n;
        q.push_back(e);
        bus.start = 1'b1;
        bus.op = op;
        bus.src1 = a;
        bus.src2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.src1 = $urandom;
        bus.src2 = $urandom;
    endtask

    task automatic issue(string n, logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [64:0] m;
        m = model(op, a, b);
        issue_exp(n, op, a, b, m[63:32], m[31:0], m[64]);
    endtask

    task automatic wait_done(string n);
        int k = 0;
        while (!bus.done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({n, "_timeout"}, 64'(bus.done), 64'd1);
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (bus.done) begin
                chk("done_not_consecutive", 64'(prev_done), 64'd0);
                chk("busy_low_in_done", 64'(bus.busy), 64'd0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                    chk({e.name, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : driver
        logic [1:0]  op;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.src1 = '0;
        bus.src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_div_zero", 64'(bus.div_zero), 64'd0);
        rst = 1'b0;
        gap();

        issue_exp("mult_7_m3", 2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        wait_done("mult_7_m3");
        gap();
        issue_exp("multu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        wait_done("multu_ff");
        issue_exp("mult_ff_b2b", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        wait_done("mult_ff_b2b");
        issue_exp("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_m7_2");
        gap();
        issue_exp("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("divu_100_7");
        issue_exp("div_overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_done("div_overflow");
        gap();
        issue_exp("divu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        wait_done("divu_5_0");
        gap();
        issue_exp("multu_3_4", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        chk("div_zero_cleared_at_start", 64'(bus.div_zero), 64'd0);
        chk("hi_held_during_calc", 64'(bus.hi), 64'd5);
        wait_done("multu_3_4");
        gap();

        issue_exp("ignored_start", 2'd1, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0);
        repeat (9) gap();
        bus.start = 1'b1;
        bus.op = 2'd3;
        bus.src1 = 32'd9;
        bus.src2 = 32'd0;
        gap();
        bus.start = 1'b0;
        wait_done("ignored_start");
        gap();

        issue("reset_victim", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) gap();
        rst = 1'b1;
        q.delete();
        gap();
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;
        repeat (40) gap();
        issue_exp("mult_2_3", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        wait_done("mult_2_3");
        gap();

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            issue("random", op, a, b);
            wait_done("random");
            if ($urandom_range(0, 1) == 1) gap();
        end
        repeat (5) gap();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
